// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg -- shared stall indices, NOP constants and occupancy encoding. Rev 1.0
`default_nettype none

package pipe_stage_reg_pkg;

  // Widest payload/write-enable field these constants can be sliced to.
  localparam int unsigned c_max_w = 1024;

  localparam int unsigned c_stall_if  = 0;
  localparam int unsigned c_stall_id  = 1;
  localparam int unsigned c_stall_ex  = 2;
  localparam int unsigned c_stall_mem = 3;
  localparam int unsigned c_stall_wb  = 4;
  localparam int unsigned c_stall_ret = 5;

  localparam logic [c_max_w-1:0] c_zero_word     = '0;
  localparam logic [c_max_w-1:0] c_write_disable = '0;
  localparam logic [c_max_w-1:0] c_nop_payload   = c_zero_word;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

`default_nettype wire

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if -- upstream/downstream handshake bundle for one pipeline stage. Rev 1.0
`default_nettype none

interface pipe_stage_reg_if #(
  parameter int DATA_W = 134,
  parameter int WE_W   = 5
);
  logic              in_valid;
  logic [WE_W-1:0]   in_we;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [WE_W-1:0]   out_we;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output in_valid, in_we, in_data, out_ready,
    input  in_ready, out_valid, out_we, out_data
  );

  modport slave (
    input  in_valid, in_we, in_data, out_ready,
    output in_ready, out_valid, out_we, out_data
  );
endinterface

`default_nettype wire

// File: rtl/pipe_stage_reg_slot.sv
// pipe_slot -- one valid/we/data holding register with load, clear and hold. Rev 1.0
`default_nettype none

module pipe_slot
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = 134,
  parameter int WE_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic              valid_in,
  input  logic [WE_W-1:0]   we_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid,
  output logic [WE_W-1:0]   we,
  output logic [DATA_W-1:0] data
);

  logic              valid_q, valid_d;
  logic [WE_W-1:0]   we_q, we_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Clear wins over load so a flushed slot always returns to NOP content.
  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
      we_d    = c_write_disable[WE_W-1:0];
      data_d  = c_nop_payload[DATA_W-1:0];
    end else if (load) begin
      valid_d = valid_in;
      we_d    = we_in;
      data_d  = data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      we_q    <= c_write_disable[WE_W-1:0];
      data_q  <= c_zero_word[DATA_W-1:0];
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign we    = we_q;
  assign data  = data_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- two-entry (main + skid) pipeline stage register with stall/flush and bubble counter. Rev 1.0
`default_nettype none

module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W  = 134,
  parameter int WE_W    = 5,
  parameter int STALL_W = 6,
  parameter int STAGE   = c_stall_wb,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  pipe_stage_reg_if.slave    bus,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   bubble_cnt
);

  occ_e             state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic              push, pop;
  logic              main_load, main_clear, main_from_skid;
  logic              skid_load, skid_clear;
  logic              main_valid, skid_valid;
  logic [WE_W-1:0]   main_we, skid_we, main_we_in;
  logic [DATA_W-1:0] main_data, skid_data, main_data_in;

  assign push = bus.in_valid & in_ready_q & ~stall[STAGE] & ~flush;
  assign pop  = main_valid & bus.out_ready & ~stall[STAGE+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= OCC_EMPTY;
      in_ready_q   <= 1'b1;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: if (push) state_d = OCC_ONE;
        OCC_ONE: begin
          if (push && !pop)      state_d = OCC_TWO;
          else if (pop && !push) state_d = OCC_EMPTY;
        end
        OCC_TWO:   if (pop) state_d = OCC_ONE;
        default:   state_d = OCC_EMPTY;
      endcase
    end
    in_ready_d = (state_d != OCC_TWO);
  end

  // Slot controls: the skid slot only ever refills main, never the output directly.
  always_comb begin
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        OCC_EMPTY: main_load = push;
        OCC_ONE: begin
          if (push && pop)  main_load  = 1'b1;
          else if (push)    skid_load  = 1'b1;
          else if (pop)     main_clear = 1'b1;
        end
        OCC_TWO: begin
          if (pop) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!main_valid && (bubble_cnt_q != {CNT_W{1'b1}}))
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  assign main_we_in   = main_from_skid ? skid_we   : bus.in_we;
  assign main_data_in = main_from_skid ? skid_data : bus.in_data;

  pipe_slot #(.DATA_W(DATA_W), .WE_W(WE_W)) u_main_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (main_load),
    .clear    (main_clear),
    .valid_in (1'b1),
    .we_in    (main_we_in),
    .data_in  (main_data_in),
    .valid    (main_valid),
    .we       (main_we),
    .data     (main_data)
  );

  pipe_slot #(.DATA_W(DATA_W), .WE_W(WE_W)) u_skid_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .clear    (skid_clear),
    .valid_in (1'b1),
    .we_in    (bus.in_we),
    .data_in  (bus.in_data),
    .valid    (skid_valid),
    .we       (skid_we),
    .data     (skid_data)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = main_valid;
  assign bus.out_we    = main_we;
  assign bus.out_data  = main_data;
  assign occupancy     = {skid_valid, main_valid & ~skid_valid};
  assign bubble_cnt    = bubble_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg -- randomized and directed checks of pipe_stage_reg against a queue model. Rev 1.0
`default_nettype none

module tb_pipe_stage_reg;

  localparam int DATA_W  = 134;
  localparam int WE_W    = 5;
  localparam int STALL_W = 6;
  localparam int STAGE   = 4;
  localparam int CNT_W   = 16;

  typedef struct {
    logic [WE_W-1:0]   we;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [1:0]         occupancy;
  logic [CNT_W-1:0]   bubble_cnt;

  pipe_stage_reg_if #(.DATA_W(DATA_W), .WE_W(WE_W)) bus ();

  pipe_stage_reg #(
    .DATA_W (DATA_W),
    .WE_W   (WE_W),
    .STALL_W(STALL_W),
    .STAGE  (STAGE),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  int unsigned      checks = 0;
  int unsigned      errors = 0;
  ent_t             q[$];
  logic [CNT_W-1:0] m_cnt = '0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DATA_W-1:0];
  endfunction

  // One clock: model decides push/pop from the same rules, then all outputs are compared.
  task automatic step();
    bit   m_push, m_pop, exp_v;
    ent_t e;
    m_push = bus.in_valid && (q.size() < 2) && !stall[STAGE] && !flush;
    m_pop  = (q.size() > 0) && bus.out_ready && !stall[STAGE+1];
    e.we   = bus.in_we;
    e.data = bus.in_data;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      m_cnt = '0;
    end else begin
      if (q.size() == 0 && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
      if (flush) q.delete();
      else begin
        if (m_pop) void'(q.pop_front());
        if (m_push) q.push_back(e);
      end
    end
    exp_v = (q.size() > 0);
    chk("occupancy",  occupancy,     q.size());
    chk("in_ready",   bus.in_ready,  q.size() < 2);
    chk("out_valid",  bus.out_valid, exp_v);
    chk("out_we",     bus.out_we,    exp_v ? q[0].we : '0);
    chk("out_data",   bus.out_data,  exp_v ? q[0].data : '0);
    chk("bubble_cnt", bubble_cnt,    m_cnt);
  endtask

  task automatic drive_in(input logic v, input logic [WE_W-1:0] we, input logic [DATA_W-1:0] d);
    bus.in_valid = v;
    bus.in_we    = we;
    bus.in_data  = d;
  endtask

  initial begin
    rst   = 1'b1;
    stall = '0;
    flush = 1'b0;
    drive_in(1'b0, '0, '0);
    bus.out_ready = 1'b0;

    step();
    chk("reset_in_ready", bus.in_ready, 1'b1);
    chk("reset_bubble",   bubble_cnt,   '0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("idle_bubble5", bubble_cnt, 5);

    // single entry passes through with one-cycle latency
    bus.out_ready = 1'b1;
    drive_in(1'b1, 5'b00001, DATA_W'(8'hA5));
    step();
    drive_in(1'b0, '0, '0);
    chk("pass_data", bus.out_data, 8'hA5);
    step();
    chk("pass_gone", bus.out_valid, 1'b0);

    // fill both slots, hold the head with downstream stall, then drain
    bus.out_ready = 1'b0;
    drive_in(1'b1, 5'b00010, DATA_W'(8'h11)); step();
    drive_in(1'b1, 5'b00100, DATA_W'(8'h22)); step();
    drive_in(1'b0, '0, '0);
    chk("full_occ",   occupancy,    2);
    chk("full_ready", bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    stall = 6'b100000;
    for (int i = 0; i < 3; i++) step();
    chk("stall_hold", bus.out_data, 8'h11);
    stall = '0;
    step();
    chk("drain_22", bus.out_data, 8'h22);
    step();
    chk("drain_empty", occupancy, 0);

    // flush beats a simultaneous push
    bus.out_ready = 1'b0;
    drive_in(1'b1, 5'b01000, DATA_W'(8'h44)); step();
    drive_in(1'b1, 5'b10000, DATA_W'(8'h55)); step();
    drive_in(1'b1, 5'b11111, DATA_W'(8'h33));
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive_in(1'b0, '0, '0);
    chk("flush_occ", occupancy,  0);
    chk("flush_we",  bus.out_we, '0);
    step();
    chk("flush_lost", bus.out_valid, 1'b0);

    // upstream stall: pop happens, push blocked, bubble emerges
    drive_in(1'b1, 5'b00011, DATA_W'(8'h66)); step();
    stall = 6'b010000;
    bus.out_ready = 1'b1;
    drive_in(1'b1, 5'b00101, DATA_W'(8'h77));
    step();
    chk("bubble_out", bus.out_valid, 1'b0);
    stall = '0;
    drive_in(1'b0, '0, '0);
    step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(199) == 0);
      flush         = ($urandom_range(31) == 0);
      stall         = STALL_W'($urandom_range(3) == 0 ? $urandom : 0);
      bus.out_ready = $urandom_range(1);
      drive_in($urandom_range(1), WE_W'($urandom), rand_data());
      step();
    end

    // long idle run to reach counter saturation
    rst = 1'b1; flush = 1'b0; stall = '0; bus.out_ready = 1'b0;
    drive_in(1'b0, '0, '0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 65540; i++) step();
    chk("bubble_sat", bubble_cnt, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 134, width of the payload carried through the stage.
REQ-002 Parameter WE_W, default 5, number of write-enable bits; these are forced to 0 on any bubble or flush.
REQ-003 Parameter STALL_W, default 6, width of the pipeline stall vector.
REQ-004 Parameter STAGE, default 4, index of this stage's own stall bit; STAGE+1 SHALL be less than STALL_W.
REQ-005 Parameter CNT_W, default 16, width of the bubble counter.
REQ-006 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 Port stall, input, STALL_W bits: pipeline stall vector.
REQ-009 Port flush, input, 1 bit: discards all held entries.
REQ-010 Port in_valid, input, 1 bit: upstream entry present.
REQ-011 Port in_we, input, WE_W bits: upstream write enables.
REQ-012 Port in_data, input, DATA_W bits: upstream payload.
REQ-013 Port in_ready, output, 1 bit: stage can accept an entry.
REQ-014 Port out_valid, output, 1 bit: head entry present.
REQ-015 Port out_we, output, WE_W bits: head write enables, 0 when not valid.
REQ-016 Port out_data, output, DATA_W bits: head payload, 0 when not valid.
REQ-017 Port out_ready, input, 1 bit: downstream accepts the head entry.
REQ-018 Port occupancy, output, 2 bits: number of entries held, 0 to 2.
REQ-019 Port bubble_cnt, output, CNT_W bits: saturating count of bubble cycles.

Function
REQ-020 The stage SHALL hold two entries: a main slot (the head) and a skid slot.
REQ-021 push = in_valid & in_ready & ~stall[STAGE] & ~flush.
REQ-022 pop = out_valid & out_ready & ~stall[STAGE+1].
REQ-023 in_ready SHALL be registered and equal to NOT(skid slot full).
REQ-024 out_valid, out_we and out_data SHALL be driven directly from the main slot registers, giving 1-cycle latency from push to out_valid when the stage is empty.
REQ-025 At occupancy 0 with push: in goes to main; occupancy becomes 1.
REQ-026 At occupancy 1 with push and no pop: in goes to skid; occupancy becomes 2; in_ready falls next cycle.
REQ-027 At occupancy 1 with push and pop: in goes to main; occupancy stays 1.
REQ-028 At occupancy 1 with pop and no push: main is cleared; occupancy becomes 0.
REQ-029 At occupancy 2 with pop: skid moves to main, skid clears, occupancy becomes 1, and in_ready rises next cycle.
REQ-030 At occupancy 2, push is impossible because in_ready is 0.
REQ-031 A cleared slot SHALL hold we=0, data=0 and valid=0 (NOP content).
REQ-032 flush SHALL take priority over push, pop and stall: both slots clear and the next cycle shows occupancy 0, out_valid 0 and in_ready 1.
REQ-033 stall[STAGE+1]=1 SHALL hold the head unchanged (no pop) while push continues into the skid slot.
REQ-034 stall[STAGE]=1 with stall[STAGE+1]=0 SHALL allow pop but no push, so a bubble propagates downstream.
REQ-035 bubble_cnt SHALL increment by 1 on every cycle where out_valid=0 and rst=0, saturating at all-ones.
REQ-036 bubble_cnt SHALL NOT be affected by flush.
REQ-037 The order of evaluation SHALL be: rst, then flush, then push/pop.

Reset
REQ-038 On rst=1 at a clock edge, both slots SHALL clear.
REQ-039 On rst=1: occupancy=0, out_valid=0, out_we=0, out_data=0, in_ready=1, bubble_cnt=0.
REQ-040 Reset asserted mid-operation SHALL discard held entries identically to flush and also clear bubble_cnt.

Structure
REQ-041 The shared defines package SHALL hold: stall index constants per stage, the NOP payload (all zero), and the WriteDisable/ZeroWord constants.
REQ-042 One sub-module, pipe_slot, SHALL implement a valid/we/data register with load, clear and hold controls, instantiated twice.

Verification
REQ-043 Reset, then idle 5 cycles -> occupancy=0, in_ready=1, out_valid=0, bubble_cnt=5.
REQ-044 Push data=0xA5 with we=5'b00001, out_ready=1 -> next cycle out_valid=1, out_data=0xA5; the following cycle out_valid=0.
REQ-045 out_ready=0, push 0x11 then 0x22 -> occupancy=2, in_ready=0; then out_ready=1 -> out_data 0x11 then 0x22, occupancy 2 -> 1 -> 0.
REQ-046 With occupancy=2, assert stall[5]=1 for 3 cycles -> out_data remains 0x11; release -> normal drain resumes.
REQ-047 With occupancy=2, assert flush together with in_valid=1 -> next cycle occupancy=0, out_we=0, and the pushed entry is lost.
REQ-048 stall[4]=1, stall[5]=0 with 1 entry held -> pop occurs, no push, out_valid=0 next cycle; bubble_cnt saturates at 0xFFFF when CNT_W=16.
